bit_serializer: RTL and testbench

Upstream feeder for the serial pattern detector. Accepts parallel words on a valid/ready handshake and emits them one bit per clock on a registered `dout`/`dout_valid` pair that connects directly to the detector's `din`/`valid` inputs. A one-word holding buffer lets consecutive words stream with no idle cycle between them, so bit patterns that span a word boundary reach the detector intact.

---
 rtl/bit_serializer_pkg.sv | 12 +
 rtl/bit_serializer_hold_buf.sv | 39 +++
 rtl/bit_serializer.sv | 108 ++++++++++
 tb/tb_bit_serializer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer: shifter FSM states and the
// default word width used by the serializer and the detector bench.
package bit_serializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

endpackage : bit_serializer_pkg

// File: rtl/bit_serializer_hold_buf.sv
// One-entry holding register with a full flag. Written when a word arrives
// while the shifter is busy, popped when the shifter reloads.
module hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            full <= 1'b0;
        end else if (wr_en) begin
            full <= 1'b1;
        end else if (rd_en) begin
            full <= 1'b0;
        end
    end

    // NOTE: the payload register is not reset; the full flag alone decides
    // whether its contents mean anything, so reset only has to clear the flag.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q <= wr_data;
        end
    end

    assign rd_data = data_q;

endmodule : hold_buf

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word holding buffer so that
// consecutive words stream out with no idle cycle between them.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shift_q;

    logic             hold_full;
    logic [WIDTH-1:0] hold_data;

    logic             xfer;
    logic             load_slot;
    logic             hold_pop;
    logic             hold_wr;
    logic             load;
    logic [WIDTH-1:0] load_word;

    logic [WIDTH-1:0] next_word;
    logic [CNT_W-1:0] next_idx;
    logic [CNT_W-1:0] sel_idx;
    logic             next_bit;

    assign in_ready = !hold_full && !rst;
    assign xfer     = in_valid && in_ready;

    // The shifter may take a new word when idle or while its last bit is out.
    assign load_slot = (state == S_IDLE) || (bit_cnt == LAST_IDX);
    assign hold_pop  = load_slot && hold_full;
    assign hold_wr   = xfer && !load_slot;
    assign load      = hold_pop || (load_slot && xfer);
    assign load_word = hold_full ? hold_data : in_data;

    hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (hold_wr),
        .wr_data (in_data),
        .rd_en   (hold_pop),
        .rd_data (hold_data),
        .full    (hold_full)
    );

    // Bit that dout must present after this edge, from either the word being
    // loaded (index 0) or the current word (next index).
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        next_word = shift_q;
        next_idx  = bit_cnt + 1'b1;
        if (load) begin
            next_word = load_word;
            next_idx  = '0;
        end
        sel_idx  = MSB_FIRST ? (LAST_IDX - next_idx) : next_idx;
        next_bit = next_word[sel_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
        end else if (load) begin
            state      <= S_SHIFT;
            bit_cnt    <= '0;
            dout       <= next_bit;
            dout_valid <= 1'b1;
        end else if (load_slot) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
        end else begin
            bit_cnt <= bit_cnt + 1'b1;
            dout    <= next_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            shift_q <= load_word;
        end
    end

    assign busy = (state == S_SHIFT) || hold_full;

endmodule : bit_serializer

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench for bit_serializer: single words in both bit
// orders, back-to-back streaming, reset mid-word, stall/resume, random stream.
module tb_bit_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       dout;
    logic       dout_valid;
    logic       busy;

    logic [7:0] l_in_data;
    logic       l_in_valid;
    logic       l_in_ready;
    logic       l_dout;
    logic       l_dout_valid;
    logic       l_busy;

    int n_checks = 0;
    int n_fail   = 0;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .in_data    (l_in_data),
        .in_valid   (l_in_valid),
        .in_ready   (l_in_ready),
        .dout       (l_dout),
        .dout_valid (l_dout_valid),
        .busy       (l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checks n MSB-first bits on the main instance, one per cycle, starting
    // at the current negedge; returns at the negedge after the last bit.
    task automatic expect_bits(input string tag, input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_bit%0d", tag, i), dout, w[7-i]);
            check($sformatf("%s_vld%0d", tag, i), dout_valid, 1'b1);
            @(negedge clk);
        end
    endtask

    logic       exp_q[$];
    logic [7:0] pat;
    int         sent;

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        l_in_valid = 1'b0;
        l_in_data  = '0;
        repeat (3) @(negedge clk);

        check("rst_dout",       dout,       1'b0);
        check("rst_dout_valid", dout_valid, 1'b0);
        check("rst_busy",       busy,       1'b0);
        check("rst_in_ready",   in_ready,   1'b0);
        check("rst_lsb_valid",  l_dout_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", in_ready, 1'b1);

        // Single word, MSB first: bits appear the cycle after the handshake.
        in_data  = 8'hB4;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        expect_bits("b4", 8'hB4);
        check("b4_idle_valid", dout_valid, 1'b0);
        check("b4_idle_dout",  dout,       1'b0);
        check("b4_idle_busy",  busy,       1'b0);

        // Back-to-back: A5 loads directly, 3C waits in the hold until A5's last bit.
        pat      = 8'hA5;
        in_data  = pat;
        in_valid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("b2b_bit%0d", k), dout, (k < 8) ? pat[7-k] : in_data[15-k]);
            check($sformatf("b2b_vld%0d", k), dout_valid, 1'b1);
            check($sformatf("b2b_rdy%0d", k), in_ready, (k >= 1 && k <= 7) ? 1'b0 : 1'b1);
            if (k == 0) in_data = 8'h3C;
            if (k == 1) in_valid = 1'b0;
            @(negedge clk);
        end
        check("b2b_end_valid", dout_valid, 1'b0);
        check("b2b_end_busy",  busy,       1'b0);

        // LSB-first instance.
        l_in_data  = 8'h01;
        l_in_valid = 1'b1;
        @(negedge clk);
        l_in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("lsb_bit%0d", i), l_dout, (i == 0) ? 1'b1 : 1'b0);
            check($sformatf("lsb_vld%0d", i), l_dout_valid, 1'b1);
            @(negedge clk);
        end
        check("lsb_end_valid", l_dout_valid, 1'b0);

        // Reset mid-word with a second word sitting in the hold.
        in_data  = 8'hFF;
        in_valid = 1'b1;
        @(negedge clk);
        check("rmw_bit0", dout, 1'b1);
        in_data = 8'h81;
        @(negedge clk);
        in_valid = 1'b0;
        check("rmw_bit1", dout, 1'b1);
        check("rmw_hold_ready", in_ready, 1'b0);
        @(negedge clk);
        check("rmw_bit2", dout, 1'b1);
        check("rmw_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("rmw_rst_valid", dout_valid, 1'b0);
        check("rmw_rst_dout",  dout,       1'b0);
        check("rmw_rst_busy",  busy,       1'b0);
        check("rmw_rst_ready", in_ready,   1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("rmw_post_valid", dout_valid, 1'b0);
        check("rmw_post_busy",  busy,       1'b0);
        check("rmw_post_ready", in_ready,   1'b1);
        in_data  = 8'h5A;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        expect_bits("rmw_5a", 8'h5A);
        check("rmw_5a_end_valid", dout_valid, 1'b0);

        // Stall and resume.
        in_data  = 8'hF0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        expect_bits("f0", 8'hF0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_vld%0d", i),  dout_valid, 1'b0);
            check($sformatf("stall_busy%0d", i), busy,       1'b0);
            @(negedge clk);
        end
        in_data  = 8'h0F;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        expect_bits("0f", 8'h0F);
        check("0f_end_valid", dout_valid, 1'b0);

        // Random stream with in_valid held high; expected bit queue must drain
        // with dout_valid high whenever bits are pending.
        sent = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (exp_q.size() > 0) begin
                check($sformatf("rnd_vld%0d", cyc), dout_valid, 1'b1);
                check($sformatf("rnd_bit%0d", cyc), dout, exp_q.pop_front());
            end else begin
                check($sformatf("rnd_idle%0d", cyc), dout_valid, 1'b0);
            end
            if (sent < 20 && in_ready) begin
                in_data  = 8'($urandom_range(0, 255));
                in_valid = 1'b1;
                for (int b = 7; b >= 0; b--) exp_q.push_back(in_data[b]);
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("rnd_words_sent", sent, 20);
        check("rnd_queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule : tb_bit_serializer
